// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- hazard and sequencing controller for the 5-stage Y86 pipeline.
//
// Decides, every cycle, whether each pipeline register (if_id, id_ex, ex_mem)
// and the PC/fetch register holds (stall) or loads a nop (bubble). It handles:
// load/use interlock, jXX mispredict flush, the three-bubble ret wait,
// data-memory back-pressure and halt. It also counts fetch cycles lost to
// f_stall for performance monitoring.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   d_icode    in   icode in decode
//   d_srcA     in   decode source register A
//   d_srcB     in   decode source register B
//   e_icode    in   icode in execute
//   e_dstM     in   execute-stage memory destination register
//   e_cnd      in   jXX condition evaluated in execute (1 = taken)
//   w_icode    in   icode in write-back
//   mem_busy   in   data memory not ready this cycle
//   f_stall    out  hold PC / fetch register
//   d_stall    out  hold if_id register
//   d_bubble   out  load nop into if_id
//   e_stall    out  hold id_ex register
//   e_bubble   out  load nop into id_ex
//   m_stall    out  hold ex_mem register
//   m_bubble   out  load nop into ex_mem (asserted only in reset)
//   halted     out  core stopped on halt
//   lost_cnt   out  saturating count of cycles with f_stall=1 since reset
//
// State table
//   state | meaning
//   RUN   | normal flow; hazards resolved combinationally
//   RET_E | ret has moved into execute; fetch held, decode bubbled
//   RET_M | ret is in memory; fetch held, decode bubbled one last time
//   HALT  | halt reached write-back; everything frozen until reset

module pipe_ctrl #(
   parameter int ICODE_W = 8,
   parameter int REG_W   = 8,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ICODE_W-1:0] d_icode,
   input  logic [REG_W-1:0]   d_srcA,
   input  logic [REG_W-1:0]   d_srcB,
   input  logic [ICODE_W-1:0] e_icode,
   input  logic [REG_W-1:0]   e_dstM,
   input  logic               e_cnd,
   input  logic [ICODE_W-1:0] w_icode,
   input  logic               mem_busy,
   output logic               f_stall,
   output logic               d_stall,
   output logic               d_bubble,
   output logic               e_stall,
   output logic               e_bubble,
   output logic               m_stall,
   output logic               m_bubble,
   output logic               halted,
   output logic [CNT_W-1:0]   lost_cnt
);

   localparam logic [ICODE_W-1:0] I_HALT   = ICODE_W'('h0);
   localparam logic [ICODE_W-1:0] I_MRMOVL = ICODE_W'('h5);
   localparam logic [ICODE_W-1:0] I_JXX    = ICODE_W'('h7);
   localparam logic [ICODE_W-1:0] I_RET    = ICODE_W'('h9);
   localparam logic [ICODE_W-1:0] I_POPL   = ICODE_W'('hB);
   localparam logic [REG_W-1:0]   RNONE    = REG_W'('hF);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      RET_E = 2'd1,
      RET_M = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic mispredict;
   logic load_use;
   logic ret_active;

   assign mispredict = (e_icode == I_JXX) && !e_cnd;
   assign load_use   = ((e_icode == I_MRMOVL) || (e_icode == I_POPL)) &&
                       (e_dstM != RNONE) &&
                       ((e_dstM == d_srcA) || (e_dstM == d_srcB));
   // A ret in decode only starts the wait from RUN; once in RET_E/RET_M the
   // sequence continues regardless of what decode now holds.
   assign ret_active = (state == RET_E) || (state == RET_M) ||
                       ((state == RUN) && (d_icode == I_RET));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (state == HALT) begin
         state_nxt = HALT;
      end else if (w_icode == I_HALT) begin
         state_nxt = HALT;
      end else if (mem_busy || mispredict || load_use) begin
         // Back-pressure freezes ret progress; a mispredict squashes a ret
         // sitting in decode, so neither advances the ret sequence.
         state_nxt = state;
      end else begin
         case (state)
            RUN:     state_nxt = (d_icode == I_RET) ? RET_E : RUN;
            RET_E:   state_nxt = RET_M;
            RET_M:   state_nxt = RUN;
            default: state_nxt = state;
         endcase
      end
   end

   // Outputs depend on rst directly so that asserting reset mid-cycle moves
   // the controls to their reset values without waiting for a clock.
   always_comb begin
      f_stall  = 1'b0;
      d_stall  = 1'b0;
      d_bubble = 1'b0;
      e_stall  = 1'b0;
      e_bubble = 1'b0;
      m_stall  = 1'b0;
      m_bubble = 1'b0;
      halted   = 1'b0;
      if (!rst) begin
         d_bubble = 1'b1;
         e_bubble = 1'b1;
         m_bubble = 1'b1;
      end else if (state == HALT) begin
         f_stall = 1'b1;
         d_stall = 1'b1;
         e_stall = 1'b1;
         m_stall = 1'b1;
         halted  = 1'b1;
      end else if (mem_busy) begin
         f_stall = 1'b1;
         d_stall = 1'b1;
         e_stall = 1'b1;
         m_stall = 1'b1;
      end else if (mispredict) begin
         d_bubble = 1'b1;
         e_bubble = 1'b1;
      end else if (load_use) begin
         f_stall  = 1'b1;
         d_stall  = 1'b1;
         e_bubble = 1'b1;
      end else if (ret_active) begin
         f_stall  = 1'b1;
         d_bubble = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lost_cnt <= '0;
      end else if (f_stall && (lost_cnt != {CNT_W{1'b1}})) begin
         lost_cnt <= lost_cnt + 1'b1;
      end
   end

   // While ret is in execute or memory, execute cannot hold a jXX, so a
   // mispredict here means the upstream pipeline is broken.
   a_no_mispredict_in_ret : assert property (
      @(posedge clk) disable iff (!rst)
      !(((state == RET_E) || (state == RET_M)) && mispredict));

endmodule
